// File: rtl/icache_line_store.sv
// Instruction-cache data array with line-fill tracking and a registered instruction output.
// Fill words must arrive in offset order on one line; anything else invalidates the lines involved.
module icache_line_store #(
  parameter int DATA_W = 8,
  parameter int LINES  = 4,
  parameter int WORDS  = 8,
  parameter logic [DATA_W-1:0] NOP = '0,
  localparam int LW = $clog2(LINES),
  localparam int OW = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cache_wren,
  input  logic [LW-1:0]     cache_wrline,
  input  logic [OW-1:0]     cache_wroffset,
  input  logic [DATA_W-1:0] rom_data,
  input  logic [LW-1:0]     cache_rdline,
  input  logic [OW-1:0]     cache_rdoffset,
  input  logic              hold_out,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  output logic [LINES-1:0]  line_valid,
  output logic              fill_busy,
  output logic [LW-1:0]     fill_line,
  output logic              fill_done,
  output logic              fill_error
);

  typedef enum logic {IDLE, FILL} state_t;

  state_t            state, state_next;
  logic [OW-1:0]     exp_off, exp_off_next;
  logic [LW-1:0]     fill_line_next;
  logic [LINES-1:0]  line_valid_next;
  logic              fill_done_next;
  logic              fill_error_next;
  logic [DATA_W-1:0] ir_next;
  logic              ir_valid_next;

  logic [DATA_W-1:0] mem [LINES][WORDS];

  // The array is never reset; a protocol error still stores the word.
  always_ff @(posedge clk) begin
    if (cache_wren) begin
      mem[cache_wrline][cache_wroffset] <= rom_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      exp_off    <= '0;
      fill_line  <= '0;
      line_valid <= '0;
      fill_done  <= 1'b0;
      fill_error <= 1'b0;
      ir         <= NOP;
      ir_valid   <= 1'b0;
    end else begin
      state      <= state_next;
      exp_off    <= exp_off_next;
      fill_line  <= fill_line_next;
      line_valid <= line_valid_next;
      fill_done  <= fill_done_next;
      fill_error <= fill_error_next;
      ir         <= ir_next;
      ir_valid   <= ir_valid_next;
    end
  end

  always_comb begin
    state_next      = state;
    exp_off_next    = exp_off;
    fill_line_next  = fill_line;
    line_valid_next = line_valid;
    fill_done_next  = 1'b0;
    fill_error_next = fill_error;
    unique case (state)
      IDLE: begin
        if (cache_wren) begin
          line_valid_next[cache_wrline] = 1'b0;
          if (cache_wroffset == '0) begin
            state_next     = FILL;
            fill_line_next = cache_wrline;
            exp_off_next   = OW'(1);
          end else begin
            fill_error_next = 1'b1;
          end
        end
      end
      FILL: begin
        // A dropped wren is a sequencer stall, not an error.
        if (cache_wren) begin
          if (cache_wrline == fill_line && cache_wroffset == exp_off) begin
            exp_off_next = exp_off + OW'(1);
            if (exp_off == OW'(WORDS - 1)) begin
              line_valid_next[fill_line] = 1'b1;
              fill_done_next             = 1'b1;
              state_next                 = IDLE;
              exp_off_next               = '0;
            end
          end else begin
            fill_error_next               = 1'b1;
            line_valid_next[fill_line]    = 1'b0;
            line_valid_next[cache_wrline] = 1'b0;
            state_next                    = IDLE;
            exp_off_next                  = '0;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    fill_busy = (state == FILL);
  end

  // Validity follows this edge's update so a completing fill reads back valid at once.
  always_comb begin
    ir_next       = NOP;
    ir_valid_next = 1'b0;
    if (!hold_out) begin
      if (cache_wren && cache_wrline == cache_rdline && cache_wroffset == cache_rdoffset) begin
        ir_next = rom_data;
      end else begin
        ir_next = mem[cache_rdline][cache_rdoffset];
      end
      ir_valid_next = line_valid_next[cache_rdline];
    end
  end

endmodule

// File: tb/tb_icache_line_store.sv
// Directed and randomized checks of icache_line_store against a line/word reference model.
module tb_icache_line_store;

  logic       clk = 1'b0;
  logic       reset;
  logic       cache_wren;
  logic [1:0] cache_wrline;
  logic [2:0] cache_wroffset;
  logic [7:0] rom_data;
  logic [1:0] cache_rdline;
  logic [2:0] cache_rdoffset;
  logic       hold_out;
  logic [7:0] ir;
  logic       ir_valid;
  logic [3:0] line_valid;
  logic       fill_busy;
  logic [1:0] fill_line;
  logic       fill_done;
  logic       fill_error;

  int total = 0;
  int bad   = 0;

  icache_line_store dut (
    .clk            (clk),
    .reset          (reset),
    .cache_wren     (cache_wren),
    .cache_wrline   (cache_wrline),
    .cache_wroffset (cache_wroffset),
    .rom_data       (rom_data),
    .cache_rdline   (cache_rdline),
    .cache_rdoffset (cache_rdoffset),
    .hold_out       (hold_out),
    .ir             (ir),
    .ir_valid       (ir_valid),
    .line_valid     (line_valid),
    .fill_busy      (fill_busy),
    .fill_line      (fill_line),
    .fill_done      (fill_done),
    .fill_error     (fill_error)
  );

  always #5 clk = ~clk;

  // Reference model: stored words, which words are known, and the fill in progress.
  logic [7:0] m_mem   [4][8];
  bit         m_known [4][8];
  bit   [3:0] m_valid;
  bit         m_filling;
  int         m_line;
  int         m_next;
  bit         m_err;
  bit         m_done;
  logic [7:0] m_ir;
  bit         m_irv;
  bit         m_ir_known;

  function automatic void model_reset();
    m_valid    = '0;
    m_filling  = 1'b0;
    m_line     = 0;
    m_next     = 0;
    m_err      = 1'b0;
    m_done     = 1'b0;
    m_ir       = 8'h00;
    m_irv      = 1'b0;
    m_ir_known = 1'b1;
  endfunction

  function automatic void model_clock();
    int wl = int'(cache_wrline);
    int wo = int'(cache_wroffset);
    int rl = int'(cache_rdline);
    int ro = int'(cache_rdoffset);
    m_done = 1'b0;
    if (cache_wren) begin
      if (!m_filling) begin
        m_valid[wl] = 1'b0;
        if (wo == 0) begin
          m_filling = 1'b1;
          m_line    = wl;
          m_next    = 1;
        end else begin
          m_err = 1'b1;
        end
      end else if (wl == m_line && wo == m_next) begin
        if (m_next == 7) begin
          m_valid[m_line] = 1'b1;
          m_done          = 1'b1;
          m_filling       = 1'b0;
          m_next          = 0;
        end else begin
          m_next = m_next + 1;
        end
      end else begin
        m_err           = 1'b1;
        m_valid[m_line] = 1'b0;
        m_valid[wl]     = 1'b0;
        m_filling       = 1'b0;
        m_next          = 0;
      end
    end
    if (hold_out) begin
      m_ir       = 8'h00;
      m_irv      = 1'b0;
      m_ir_known = 1'b1;
    end else begin
      if (cache_wren && wl == rl && wo == ro) begin
        m_ir       = rom_data;
        m_ir_known = 1'b1;
      end else begin
        m_ir       = m_mem[rl][ro];
        m_ir_known = m_known[rl][ro];
      end
      m_irv = m_valid[rl];
    end
    if (cache_wren) begin
      m_mem[wl][wo]   = rom_data;
      m_known[wl][wo] = 1'b1;
    end
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    if (m_ir_known) check("ir", ir, m_ir);
    check("ir_valid",   8'(ir_valid),   8'(m_irv));
    check("line_valid", 8'(line_valid), 8'(m_valid));
    check("fill_busy",  8'(fill_busy),  8'(m_filling));
    check("fill_line",  8'(fill_line),  8'(m_line));
    check("fill_done",  8'(fill_done),  8'(m_done));
    check("fill_error", 8'(fill_error), 8'(m_err));
  endtask

  task automatic apply_stimulus(input logic wren, input logic [1:0] wl, input logic [2:0] wo,
                                input logic [7:0] data, input logic [1:0] rl, input logic [2:0] ro,
                                input logic hold);
    cache_wren     = wren;
    cache_wrline   = wl;
    cache_wroffset = wo;
    rom_data       = data;
    cache_rdline   = rl;
    cache_rdoffset = ro;
    hold_out       = hold;
    @(posedge clk);
    model_clock();
    #1;
    check_output();
  endtask

  // Called 1ns after an edge; reset is asserted and released well away from the next edge.
  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_output();
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int r;
    logic [1:0] wl, rl;
    logic [2:0] wo, ro;
    logic       wren;
    cache_wren = 1'b0; cache_wrline = '0; cache_wroffset = '0; rom_data = '0;
    cache_rdline = '0; cache_rdoffset = '0; hold_out = 1'b1;
    for (int l = 0; l < 4; l++)
      for (int w = 0; w < 8; w++) begin
        m_mem[l][w]   = 8'h00;
        m_known[l][w] = 1'b0;
      end
    reset = 1'b1;
    #2;
    model_reset();
    check_output();
    check("reset_ir", ir, 8'h00);
    check("reset_line_valid", 8'(line_valid), 8'h00);
    check("reset_fill_error", 8'(fill_error), 8'h00);
    #1;
    reset = 1'b0;

    $display("[TB] full fill of line 2");
    for (int o = 0; o < 8; o++)
      apply_stimulus(1'b1, 2'd2, 3'(o), 8'hA0 + 8'(o), 2'd0, 3'd0, 1'b1);
    check("fill2_done", 8'(fill_done), 8'h01);
    check("fill2_line_valid", 8'(line_valid), 8'h04);
    apply_stimulus(1'b0, 2'd0, 3'd0, 8'h00, 2'd2, 3'd5, 1'b0);
    check("read25_ir", ir, 8'hA5);
    check("read25_ir_valid", 8'(ir_valid), 8'h01);
    check("fill2_done_pulse", 8'(fill_done), 8'h00);

    $display("[TB] stalled fill of line 1");
    for (int o = 0; o < 4; o++)
      apply_stimulus(1'b1, 2'd1, 3'(o), 8'h10 + 8'(o), 2'd2, 3'(o), 1'b0);
    for (int s = 0; s < 3; s++)
      apply_stimulus(1'b0, 2'd0, 3'd0, 8'hFF, 2'd1, 3'd1, 1'b0);
    check("stall_busy", 8'(fill_busy), 8'h01);
    for (int o = 4; o < 8; o++)
      apply_stimulus(1'b1, 2'd1, 3'(o), 8'h10 + 8'(o), 2'd1, 3'(o), 1'b0);
    check("stall_no_error", 8'(fill_error), 8'h00);
    check("stall_line_valid", 8'(line_valid), 8'h06);
    check("stall_completion_read", 8'(ir_valid), 8'h01);

    $display("[TB] out-of-order fill of line 0");
    apply_stimulus(1'b1, 2'd0, 3'd0, 8'h30, 2'd0, 3'd0, 1'b1);
    apply_stimulus(1'b1, 2'd0, 3'd1, 8'h31, 2'd0, 3'd0, 1'b1);
    apply_stimulus(1'b1, 2'd0, 3'd3, 8'h33, 2'd0, 3'd0, 1'b1);
    check("skip_error", 8'(fill_error), 8'h01);
    check("skip_idle", 8'(fill_busy), 8'h00);
    check("skip_line_valid", 8'(line_valid), 8'h06);
    for (int s = 0; s < 3; s++)
      apply_stimulus(1'b0, 2'd0, 3'd0, 8'h00, 2'd1, 3'd7, 1'b0);
    check("error_sticky", 8'(fill_error), 8'h01);

    $display("[TB] write forwarding");
    apply_stimulus(1'b1, 2'd3, 3'd4, 8'h11, 2'd0, 3'd0, 1'b1);
    apply_stimulus(1'b1, 2'd3, 3'd4, 8'h5C, 2'd3, 3'd4, 1'b0);
    check("forward_ir", ir, 8'h5C);

    $display("[TB] hold and reset mid-fill");
    apply_stimulus(1'b0, 2'd0, 3'd0, 8'h00, 2'd2, 3'd3, 1'b1);
    check("hold_ir", ir, 8'h00);
    check("hold_ir_valid", 8'(ir_valid), 8'h00);
    for (int o = 0; o < 6; o++)
      apply_stimulus(1'b1, 2'd0, 3'(o), 8'h40 + 8'(o), 2'd1, 3'd2, 1'b0);
    check("midfill_busy", 8'(fill_busy), 8'h01);
    pulse_reset();
    check("reset_midfill_busy", 8'(fill_busy), 8'h00);
    check("reset_midfill_valid", 8'(line_valid), 8'h00);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 800; n++) begin
      if (n % 200 == 199) begin
        pulse_reset();
      end
      r  = int'($urandom_range(0, 9));
      wl = 2'($urandom_range(0, 3));
      wo = 3'($urandom_range(0, 7));
      wren = 1'b1;
      if (r < 6) begin
        if (m_filling) begin
          wl = 2'(m_line);
          wo = 3'(m_next);
        end else begin
          wo = 3'd0;
        end
      end else if (r < 8) begin
        wren = 1'b0;
      end
      if ($urandom_range(0, 1) == 0) begin
        rl = wl;
        ro = wo;
      end else begin
        rl = 2'($urandom_range(0, 3));
        ro = 3'($urandom_range(0, 7));
      end
      apply_stimulus(wren, wl, wo, 8'($urandom), rl, ro, ($urandom_range(0, 4) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
